vector_writeback: RTL and testbench
===================================

# vector_writeback

Downstream stage of the vector lanes: captures the concatenated per-lane results of one vector instruction together with its destination register, queues them in a small in-order FIFO, and drains them to the vector register file over a valid/ready write port. It also reports read-after-write hazards for pending destination registers back to the issue logic, so operands are never read stale.

## Interface
- LANES, 4, number of lanes concatenated on lane_data (lane i occupies bits [WIDTH*(i+1)-1 : WIDTH*i])
- WIDTH, 8, bits per lane element
- DEPTH, 4, FIFO entries; power of two, ≥2
- REGW, 3, vector register address width

- clock  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low
- in_valid  input  1  lane results for one instruction are present
- in_ready  output  1  stage can accept this cycle
- in_op  input  4  opcode of the instruction that produced lane_data
- in_vd_addr  input  REGW  destination vector register
- lane_data  input  LANES*WIDTH  concatenated lane data_out values
- wr_en  output  1  head entry valid toward register file
- wr_ready  input  1  register file accepts this cycle
- wr_addr  output  REGW  destination of head entry
- wr_data  output  LANES*WIDTH  data of head entry
- rd_addr_a  input  REGW  issue-side Vs address for hazard check
- rd_addr_b  input  REGW  issue-side Vt address for hazard check
- hazard  output  1  a pending entry targets rd_addr_a or rd_addr_b
- count  output  $clog2(DEPTH)+1  number of occupied entries

## Operation
- Accept handshake: in_valid && in_ready. in_ready = (count != DEPTH); it is purely a function of registered state and never depends on wr_ready.
- Push: an accepted transfer with in_op != 4'b0000 writes {in_vd_addr, lane_data} at the tail and advances the tail.
- Discard: an accepted transfer with in_op == 4'b0000 (no-op; lanes output 0) completes the handshake and is dropped. No entry is written and count is unchanged.
- Pop: wr_en = (count != 0). The head advances when wr_en && wr_ready.
- Output drive: wr_addr and wr_data show the head entry whenever wr_en = 1, and are 0 when empty.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count tracks occupancy:
  - +1 on push only
  - −1 on pop only
  - unchanged on simultaneous push and pop
- Full: a push is impossible because in_ready = 0. A pop in that cycle frees one entry, and in_ready rises the next cycle.
- Empty: a pop is impossible because wr_en = 0. A push in that cycle makes wr_en = 1 the next cycle.
- Order: entries leave strictly in arrival order. Two entries with the same address are both written, the older first.
- Hazard: combinational OR over all occupied entries of (addr == rd_addr_a || addr == rd_addr_b).
  - An entry popped this cycle still counts.
  - An entry being pushed this cycle does not count until the next cycle.
- Reset (asserted low, any time, including mid-drain):
  - pointers and count → 0
  - all entry storage → 0
  - wr_en = 0, wr_addr = 0, wr_data = 0, hazard = 0, in_ready = 1
  - in-flight entries are lost
  - the first accept is possible on the first rising edge after deassertion

## Timing
- Latency in_valid accept → wr_en: 1 cycle when empty. Otherwise the entry waits behind the entries already queued.
- Throughput: one accept and one write per cycle sustained when wr_ready = 1.
- in_ready, wr_en, wr_addr, wr_data and count are registered-state outputs with no combinational path from in_valid or wr_ready.
- hazard is combinational from rd_addr_a/b and registered state only.
- wr_ready may toggle arbitrarily. The head entry is held stable while wr_en && !wr_ready.

## Test plan
- Single write: reset, push op=0001, vd=3, lane_data=32'hA1B2C3D4 with wr_ready=1. Required:
  - wr_en=1, wr_addr=3, wr_data=32'hA1B2C3D4 exactly one cycle after the accept
  - count returns to 0 the cycle after that
- Fill and backpressure: wr_ready=0, push 4 entries with vd=0..3. Required:
  - in_ready=0 with count=4, and a 5th in_valid is not accepted
  - raise wr_ready: writes appear in order 0,1,2,3 on consecutive cycles
  - in_ready=1 one cycle after the first pop
- Simultaneous push/pop at count=2 with wr_ready=1 and in_valid=1 for 6 cycles: count stays 2 and all data exits in order. Continue past 6 pushes so the pointers wrap.
- No-op discard: push op=0000, vd=5. Required: in_ready handshake completes, count stays 0, wr_en stays 0, hazard with rd_addr_a=5 stays 0.
- Hazard: queue vd=2 with wr_ready=0. Required:
  - rd_addr_b=2 → hazard=1
  - rd_addr_a=rd_addr_b=6 → hazard=0
  - after the vd=2 entry pops → hazard=0 on the next cycle
- Reset mid-drain: 3 entries queued, wr_ready=1, reset pulsed low between clock edges. Required: wr_en, count and hazard → 0 immediately (asynchronous), in_ready=1, and no further writes occur after release.

Source files
------------

// File: rtl/vector_writeback.sv
// Writeback stage for vector lane results: an in-order FIFO of {vd, data} that drains
// to the register file and reports RAW hazards on pending destinations.
module vector_writeback #(
  parameter int LANES = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int REGW  = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_op,
  input  logic [REGW-1:0]          in_vd_addr,
  input  logic [LANES*WIDTH-1:0]   lane_data,
  output logic                     wr_en,
  input  logic                     wr_ready,
  output logic [REGW-1:0]          wr_addr,
  output logic [LANES*WIDTH-1:0]   wr_data,
  input  logic [REGW-1:0]          rd_addr_a,
  input  logic [REGW-1:0]          rd_addr_b,
  output logic                     hazard,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int DW = LANES * WIDTH;
  localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

  logic [REGW-1:0] r_addr [DEPTH];
  logic [DW-1:0]   r_data [DEPTH];
  logic [DEPTH-1:0] r_occ;
  logic [PW-1:0]   r_wr;
  logic [PW-1:0]   r_rd;
  logic [PW:0]     r_count;

  logic w_push;
  logic w_pop;

  assign in_ready = (r_count != FULL);
  assign wr_en    = (r_count != '0);
  // No-op instructions complete the handshake but never occupy an entry
  assign w_push   = in_valid && in_ready && (in_op != 4'b0000);
  assign w_pop    = wr_en && wr_ready;
  assign count    = r_count;
  assign wr_addr  = wr_en ? r_addr[r_rd] : '0;
  assign wr_data  = wr_en ? r_data[r_rd] : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
      r_occ   <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_addr[r_wr] <= in_vd_addr;
        r_data[r_wr] <= lane_data;
        r_occ[r_wr]  <= 1'b1;
        r_wr         <= r_wr + 1'b1;
      end
      // Push and pop never share a slot: push needs not-full, pop needs not-empty
      if (w_pop) begin
        r_occ[r_rd] <= 1'b0;
        r_rd        <= r_rd + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Occupancy bits make the head entry count until it actually leaves
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_occ[i] && ((r_addr[i] == rd_addr_a) || (r_addr[i] == rd_addr_b)))
        hazard = 1'b1;
    end
  end

endmodule

// File: tb/tb_vector_writeback.sv
// Directed bench for vector_writeback: vector table for single-cycle behaviour,
// hand sequences for streaming with wrap and asynchronous reset mid-drain.
module tb_vector_writeback;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [2:0]  in_vd_addr;
  logic [31:0] lane_data;
  logic        wr_en;
  logic        wr_ready;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic [2:0]  rd_addr_a;
  logic [2:0]  rd_addr_b;
  logic        hazard;
  logic [2:0]  count;

  int checks = 0;
  int failures = 0;

  vector_writeback #(.LANES(4), .WIDTH(8), .DEPTH(4), .REGW(3)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_vd_addr(in_vd_addr), .lane_data(lane_data),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .hazard(hazard), .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        iv;
    logic [3:0]  op;
    logic [2:0]  vd;
    logic [31:0] d;
    logic        wrr;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic        e_ir;
    logic        e_we;
    logic [2:0]  e_wa;
    logic [31:0] e_wd;
    logic [2:0]  e_cnt;
    logic        e_hz;
  } vec_t;

  typedef struct {
    logic [2:0]  a;
    logic [31:0] d;
  } ent_t;

  vec_t vt [21];
  ent_t q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic iv, input logic [3:0] op, input logic [2:0] vd,
                              input logic [31:0] d, input logic wrr, input logic [2:0] ra,
                              input logic [2:0] rb, input logic e_ir, input logic e_we,
                              input logic [2:0] e_wa, input logic [31:0] e_wd,
                              input logic [2:0] e_cnt, input logic e_hz);
    vec_t v;
    v.iv = iv; v.op = op; v.vd = vd; v.d = d; v.wrr = wrr; v.ra = ra; v.rb = rb;
    v.e_ir = e_ir; v.e_we = e_we; v.e_wa = e_wa; v.e_wd = e_wd; v.e_cnt = e_cnt; v.e_hz = e_hz;
    return v;
  endfunction

  initial begin
    // Expected columns describe outputs before the edge that consumes the row's inputs
    //          iv op vd d             wrr ra rb  ir we wa wd             cnt hz
    vt[0]  = mk(0, 0, 0, 32'h0,        1,  7, 7,  1, 0, 0, 32'h0,        0,  0);
    vt[1]  = mk(1, 1, 3, 32'hA1B2C3D4, 1,  3, 3,  1, 0, 0, 32'h0,        0,  0);
    vt[2]  = mk(0, 0, 0, 32'h0,        1,  3, 7,  1, 1, 3, 32'hA1B2C3D4, 1,  1);
    vt[3]  = mk(0, 0, 0, 32'h0,        1,  3, 7,  1, 0, 0, 32'h0,        0,  0);
    vt[4]  = mk(1, 0, 5, 32'h0,        1,  5, 0,  1, 0, 0, 32'h0,        0,  0);
    vt[5]  = mk(0, 0, 0, 32'h0,        1,  5, 0,  1, 0, 0, 32'h0,        0,  0);
    vt[6]  = mk(1, 2, 2, 32'h11223344, 0,  6, 6,  1, 0, 0, 32'h0,        0,  0);
    vt[7]  = mk(0, 0, 0, 32'h0,        0,  0, 2,  1, 1, 2, 32'h11223344, 1,  1);
    vt[8]  = mk(0, 0, 0, 32'h0,        0,  6, 6,  1, 1, 2, 32'h11223344, 1,  0);
    vt[9]  = mk(0, 0, 0, 32'h0,        1,  2, 2,  1, 1, 2, 32'h11223344, 1,  1);
    vt[10] = mk(0, 0, 0, 32'h0,        0,  2, 2,  1, 0, 0, 32'h0,        0,  0);
    vt[11] = mk(1, 1, 0, 32'h10,       0,  7, 7,  1, 0, 0, 32'h0,        0,  0);
    vt[12] = mk(1, 1, 1, 32'h11,       0,  7, 7,  1, 1, 0, 32'h10,       1,  0);
    vt[13] = mk(1, 1, 2, 32'h12,       0,  7, 7,  1, 1, 0, 32'h10,       2,  0);
    vt[14] = mk(1, 1, 3, 32'h13,       0,  7, 7,  1, 1, 0, 32'h10,       3,  0);
    vt[15] = mk(1, 1, 4, 32'h14,       0,  7, 7,  0, 1, 0, 32'h10,       4,  0);
    vt[16] = mk(0, 0, 0, 32'h0,        1,  4, 4,  0, 1, 0, 32'h10,       4,  0);
    vt[17] = mk(0, 0, 0, 32'h0,        1,  4, 4,  1, 1, 1, 32'h11,       3,  0);
    vt[18] = mk(0, 0, 0, 32'h0,        1,  4, 4,  1, 1, 2, 32'h12,       2,  0);
    vt[19] = mk(0, 0, 0, 32'h0,        1,  4, 4,  1, 1, 3, 32'h13,       1,  0);
    vt[20] = mk(0, 0, 0, 32'h0,        1,  4, 4,  1, 0, 0, 32'h0,        0,  0);

    reset = 1'b0; in_valid = 1'b0; in_op = '0; in_vd_addr = '0; lane_data = '0;
    wr_ready = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 21; i++) begin
      in_valid = vt[i].iv; in_op = vt[i].op; in_vd_addr = vt[i].vd; lane_data = vt[i].d;
      wr_ready = vt[i].wrr; rd_addr_a = vt[i].ra; rd_addr_b = vt[i].rb;
      #1;
      chk($sformatf("r%0d_in_ready", i), 32'(in_ready), 32'(vt[i].e_ir));
      chk($sformatf("r%0d_wr_en", i),    32'(wr_en),    32'(vt[i].e_we));
      chk($sformatf("r%0d_wr_addr", i),  32'(wr_addr),  32'(vt[i].e_wa));
      chk($sformatf("r%0d_wr_data", i),  wr_data,       vt[i].e_wd);
      chk($sformatf("r%0d_count", i),    32'(count),    32'(vt[i].e_cnt));
      chk($sformatf("r%0d_hazard", i),   32'(hazard),   32'(vt[i].e_hz));
      @(negedge clock);
    end

    // Streaming at count=2 with simultaneous push and pop; pointers wrap twice
    in_valid = 1'b0; wr_ready = 1'b0; rd_addr_a = 3'd7; rd_addr_b = 3'd7;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_op = 4'd1; in_vd_addr = 3'(k); lane_data = 32'h20 + k;
      q.push_back('{a: 3'(k), d: 32'h20 + k});
      @(negedge clock);
    end
    for (int k = 2; k < 10; k++) begin
      in_valid = 1'b1; in_op = 4'd5; in_vd_addr = 3'(k % 8); lane_data = 32'h20 + k;
      wr_ready = 1'b1;
      #1;
      chk($sformatf("stream%0d_count", k), 32'(count), 32'd2);
      chk($sformatf("stream%0d_wr_en", k), 32'(wr_en), 32'd1);
      chk($sformatf("stream%0d_wr_addr", k), 32'(wr_addr), 32'(q[0].a));
      chk($sformatf("stream%0d_wr_data", k), wr_data, q[0].d);
      void'(q.pop_front());
      q.push_back('{a: 3'(k % 8), d: 32'h20 + k});
      @(negedge clock);
    end
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("drain%0d_wr_addr", k), 32'(wr_addr), 32'(q[0].a));
      chk($sformatf("drain%0d_wr_data", k), wr_data, q[0].d);
      void'(q.pop_front());
      @(negedge clock);
    end
    #1;
    chk("drain_count", 32'(count), 32'd0);
    @(negedge clock);

    // Asynchronous reset while three entries are draining
    wr_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      in_valid = 1'b1; in_op = 4'd2; in_vd_addr = 3'(k); lane_data = 32'h30 + k;
      @(negedge clock);
    end
    in_valid = 1'b0; rd_addr_a = 3'd1; rd_addr_b = 3'd1;
    #1;
    chk("rst_pre_count", 32'(count), 32'd3);
    chk("rst_pre_hazard", 32'(hazard), 32'd1);
    wr_ready = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_hazard", 32'(hazard), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("post_rst%0d_wr_en", k), 32'(wr_en), 32'd0);
      chk($sformatf("post_rst%0d_count", k), 32'(count), 32'd0);
      @(negedge clock);
    end
    in_valid = 1'b1; in_op = 4'd3; in_vd_addr = 3'd6; lane_data = 32'hCAFEF00D;
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    chk("post_rst_push_wr_en", 32'(wr_en), 32'd1);
    chk("post_rst_push_wr_addr", 32'(wr_addr), 32'd6);
    chk("post_rst_push_wr_data", wr_data, 32'hCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
